useq_sequencer: RTL and testbench

- Microprogram sequencer that sits directly upstream of the Am2901 bit-slice.
- Each cycle it produces the next control-store address `y`. The control-store word at that address supplies the 2901's i/a/b/d fields.
- Simplified Am2910 style: micro-PC register, LIFO return/loop stack, down-counter, 8-instruction set.
- Conditional branches use the 2901 status flags (z, ovr, cout, f3), selected externally onto `cond`.

---
 rtl/useq_sequencer.sv | 61 ++++++
 tb/tb_useq_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/useq_sequencer.sv
// useq_sequencer: Am2910-style microprogram sequencer (cp/rst_lo clock+async reset; i/cond/d/hold in; y next address, full_lo/empty_lo stack flags out)
module useq_sequencer #(
    parameter int AW    = 8,
    parameter int DEPTH = 5
) (
    input  logic          cp,
    input  logic          rst_lo,
    input  logic [2:0]    i,
    input  logic          cond,
    input  logic [AW-1:0] d,
    input  logic          hold,
    output logic [AW-1:0] y,
    output logic          full_lo,
    output logic          empty_lo
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] SP_MAX = SW'(DEPTH);
    localparam logic [2:0] JZ = 3'd0, CJS = 3'd1, PUSH = 3'd2, CJP = 3'd3;
    localparam logic [2:0] LDCT = 3'd4, RFCT = 3'd5, CRTN = 3'd6;
    logic [AW-1:0] upc_q, upc_d, cnt_q, cnt_d, tos;
    logic [SW-1:0] sp_q, sp_d;
    logic [AW-1:0] stk_q [DEPTH];
    logic [AW-1:0] stk_d [DEPTH];
    logic          push, pop, cnt_nz;
    always_comb begin
        cnt_nz = cnt_q != '0;
        tos    = (sp_q == '0) ? '0 : stk_q[sp_q - SW'(1)];
        y      = (i == JZ) ? '0 :
                 ((i == CJS || i == CJP) && cond) ? d :
                 ((i == RFCT && cnt_nz) || (i == CRTN && cond)) ? tos : upc_q;
        push   = (i == CJS && cond) || i == PUSH;
        pop    = (i == RFCT && !cnt_nz) || (i == CRTN && cond);
        upc_d  = hold ? upc_q : y + AW'(1);
        cnt_d  = hold ? cnt_q :
                 (i == LDCT || (i == PUSH && cond)) ? d :
                 (i == RFCT && cnt_nz) ? cnt_q - AW'(1) : cnt_q;
        // a full stack saturates: the top entry is overwritten and sp stays put
        sp_d   = hold ? sp_q :
                 (i == JZ) ? '0 :
                 push ? ((sp_q == SP_MAX) ? sp_q : sp_q + SW'(1)) :
                 pop ? ((sp_q == '0) ? sp_q : sp_q - SW'(1)) : sp_q;
        stk_d  = stk_q;
        if (!hold && push)
            stk_d[(sp_q == SP_MAX) ? SP_MAX - SW'(1) : sp_q] = upc_q;
    end
    always_ff @(posedge cp or negedge rst_lo) begin
        if (!rst_lo) begin
            upc_q <= '0;
            cnt_q <= '0;
            sp_q  <= '0;
            stk_q <= '{default: '0};
        end else begin
            upc_q <= upc_d;
            cnt_q <= cnt_d;
            sp_q  <= sp_d;
            stk_q <= stk_d;
        end
    end
    assign full_lo  = sp_q != SP_MAX;
    assign empty_lo = sp_q != '0;
endmodule

// File: tb/tb_useq_sequencer.sv
// tb_useq_sequencer: table-driven scoreboard bench for useq_sequencer
module tb_useq_sequencer;
    logic       cp = 1'b0;
    logic       rst_lo = 1'b0;
    logic [2:0] i = 3'd7;
    logic       cond = 1'b0;
    logic [7:0] d = '0;
    logic       hold = 1'b0;
    logic [7:0] y;
    logic       full_lo, empty_lo;
    typedef struct {
        logic [2:0] i;
        logic       cond;
        logic [7:0] d;
        logic       hold;
        logic [7:0] y;
        logic       f;
        logic       e;
    } vec_t;
    typedef struct {
        int         n;
        logic [7:0] y;
        logic       f;
        logic       e;
    } exp_t;
    vec_t tv[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag = 0;
    useq_sequencer #(.AW(8), .DEPTH(5)) dut (
        .cp(cp), .rst_lo(rst_lo), .i(i), .cond(cond), .d(d), .hold(hold),
        .y(y), .full_lo(full_lo), .empty_lo(empty_lo)
    );
    always #5 cp = ~cp;
    function automatic vec_t v(input logic [2:0] vi, input logic vc, input logic [7:0] vd,
                               input logic vh, input logic [7:0] vy, input logic vf, input logic ve);
        vec_t r;
        r.i = vi; r.cond = vc; r.d = vd; r.hold = vh; r.y = vy; r.f = vf; r.e = ve;
        return r;
    endfunction
    task automatic put(input vec_t t);
        exp_t x;
        i = t.i; cond = t.cond; d = t.d; hold = t.hold;
        x.n = tag; x.y = t.y; x.f = t.f; x.e = t.e;
        tag++;
        sb.push_back(x);
    endtask
    task automatic chk();
        exp_t x;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty");
            return;
        end
        x = sb.pop_front();
        checks += 3;
        if (y !== x.y) begin
            errors++;
            $display("FAIL step %0d y: got %h expected %h", x.n, y, x.y);
        end
        if (full_lo !== x.f) begin
            errors++;
            $display("FAIL step %0d full_lo: got %b expected %b", x.n, full_lo, x.f);
        end
        if (empty_lo !== x.e) begin
            errors++;
            $display("FAIL step %0d empty_lo: got %b expected %b", x.n, empty_lo, x.e);
        end
    endtask
    task automatic apply(input vec_t t);
        put(t);
        #1 chk();
        @(negedge cp);
    endtask
    initial begin
        // reset / CONT
        tv.push_back(v(7,0,8'h00,0,8'h00,1,0));
        tv.push_back(v(7,0,8'h00,0,8'h01,1,0));
        tv.push_back(v(7,0,8'h00,0,8'h02,1,0));
        // call and return
        tv.push_back(v(3,1,8'h0F,0,8'h0F,1,0));
        tv.push_back(v(1,1,8'h40,0,8'h40,1,0));
        tv.push_back(v(7,0,8'h00,0,8'h41,1,1));
        tv.push_back(v(6,1,8'h00,0,8'h10,1,1));
        tv.push_back(v(6,0,8'h00,0,8'h11,1,0));
        tv.push_back(v(3,0,8'h99,0,8'h12,1,0));
        // loop of three passes
        tv.push_back(v(3,1,8'h1F,0,8'h1F,1,0));
        tv.push_back(v(2,1,8'h02,0,8'h20,1,0));
        tv.push_back(v(5,0,8'h00,0,8'h20,1,1));
        tv.push_back(v(5,0,8'h00,0,8'h20,1,1));
        tv.push_back(v(5,0,8'h00,0,8'h21,1,1));
        tv.push_back(v(7,0,8'h00,0,8'h22,1,0));
        // RFCT on empty stack, LDCT, PUSH without counter load
        tv.push_back(v(4,0,8'h01,0,8'h23,1,0));
        tv.push_back(v(5,0,8'h00,0,8'h00,1,0));
        tv.push_back(v(5,0,8'h00,0,8'h01,1,0));
        tv.push_back(v(7,0,8'h00,0,8'h02,1,0));
        tv.push_back(v(4,0,8'h02,0,8'h03,1,0));
        tv.push_back(v(2,0,8'h07,0,8'h04,1,0));
        tv.push_back(v(5,0,8'h00,0,8'h04,1,1));
        tv.push_back(v(5,0,8'h00,0,8'h04,1,1));
        tv.push_back(v(5,0,8'h00,0,8'h05,1,1));
        tv.push_back(v(7,0,8'h00,0,8'h06,1,0));
        // overflow
        tv.push_back(v(1,1,8'h50,0,8'h50,1,0));
        tv.push_back(v(1,1,8'h51,0,8'h51,1,1));
        tv.push_back(v(1,1,8'h52,0,8'h52,1,1));
        tv.push_back(v(1,1,8'h53,0,8'h53,1,1));
        tv.push_back(v(1,1,8'h54,0,8'h54,1,1));
        tv.push_back(v(1,1,8'h55,0,8'h55,0,1));
        // underflow
        tv.push_back(v(6,1,8'h00,0,8'h55,0,1));
        tv.push_back(v(6,1,8'h00,0,8'h53,1,1));
        tv.push_back(v(6,1,8'h00,0,8'h52,1,1));
        tv.push_back(v(6,1,8'h00,0,8'h51,1,1));
        tv.push_back(v(6,1,8'h00,0,8'h07,1,1));
        tv.push_back(v(6,1,8'h00,0,8'h00,1,0));
        tv.push_back(v(7,0,8'h00,0,8'h01,1,0));
        // hold
        tv.push_back(v(1,1,8'h77,1,8'h77,1,0));
        tv.push_back(v(7,0,8'h00,0,8'h02,1,0));
        tv.push_back(v(4,0,8'h05,1,8'h03,1,0));
        tv.push_back(v(5,0,8'h00,0,8'h03,1,0));
        // wrap
        tv.push_back(v(3,1,8'hFE,0,8'hFE,1,0));
        tv.push_back(v(7,0,8'h00,0,8'hFF,1,0));
        tv.push_back(v(7,0,8'h00,0,8'h00,1,0));
        // JZ clears a three-deep stack
        tv.push_back(v(2,0,8'h00,0,8'h01,1,0));
        tv.push_back(v(2,0,8'h00,0,8'h02,1,1));
        tv.push_back(v(2,0,8'h00,0,8'h03,1,1));
        tv.push_back(v(0,1,8'h33,0,8'h00,1,1));
        tv.push_back(v(7,0,8'h00,0,8'h01,1,0));
        tv.push_back(v(6,1,8'h00,0,8'h00,1,0));
        repeat (2) @(negedge cp);
        put(v(7,0,8'h00,0,8'h00,1,0));
        #1 chk();
        @(negedge cp);
        rst_lo = 1'b1;
        for (int k = 0; k < tv.size(); k++) apply(tv[k]);
        // asynchronous reset in the middle of a counted loop
        apply(v(3,1,8'h2F,0,8'h2F,1,0));
        apply(v(2,1,8'h03,0,8'h30,1,0));
        put(v(5,0,8'h00,0,8'h30,1,1));
        #1 chk();
        #1 rst_lo = 1'b0;
        put(v(5,0,8'h00,0,8'h00,1,0));
        #1 chk();
        @(negedge cp);
        rst_lo = 1'b1;
        apply(v(3,1,8'h0F,0,8'h0F,1,0));
        apply(v(2,0,8'h00,0,8'h10,1,0));
        apply(v(5,0,8'h00,0,8'h11,1,1));
        apply(v(7,0,8'h00,0,8'h12,1,0));
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
